// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared types and default sizes for the register rename unit
// Contents:
//   *_DEF              default configuration (32 arch, 64 phys, 32-bit data, 4 checkpoints)
//   arch/phys/ckpt_idx_t  index types for the default configuration
//   ckpt_t             branch snapshot: map table plus free list
//   idx_width()        index width of an n-entry table, never below 1
package rename_pkg;

  localparam int ARCH_REGS_DEF  = 32;
  localparam int PHYS_REGS_DEF  = 64;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_CKPT_DEF   = 4;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int ARCH_W = idx_width(ARCH_REGS_DEF);
  localparam int PHYS_W = idx_width(PHYS_REGS_DEF);
  localparam int CKPT_W = idx_width(NUM_CKPT_DEF);

  typedef logic [ARCH_W-1:0] arch_idx_t;
  typedef logic [PHYS_W-1:0] phys_idx_t;
  typedef logic [CKPT_W-1:0] ckpt_idx_t;

  typedef struct packed {
    phys_idx_t [ARCH_REGS_DEF-1:0] map;
    logic      [PHYS_REGS_DEF-1:0] free;
  } ckpt_t;

endpackage

// File: rtl/free_list_alloc.sv
// rtl/free_list_alloc.sv - lowest-free-register picker and free population count
// Ports:
//   vec    in   N       free bit per physical register
//   idx    out  IW      lowest set index (0 when none)
//   valid  out  1       at least one bit set
//   count  out  IW+1    number of set bits
module free_list_alloc #(
  parameter int N  = 64,
  parameter int IW = 6
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid,
  output logic [IW:0]   count
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    count = '0;
    // Scan downwards so the last hit, i.e. the lowest index, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      count = count + (IW + 1)'(vec[i]);
    end
  end

endmodule

// File: rtl/rename_unit.sv
// rtl/rename_unit.sv - arch->phys rename with free list, register file and branch checkpoints
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   ren_valid/ren_is_branch            instruction to rename / needs a checkpoint
//   ren_rs/rt/rw, ren_uses_rs/rt/rw    arch operands and their use flags
//   ren_ready                          rename accepted this cycle
//   rs/rt_phys, rs/rt_data, rs/rt_rdy  source mapping, value, produced flag
//   rw_phys_new/rw_phys_old            allocated dest / previous dest mapping
//   ckpt_id                            checkpoint slot taken by a branch
//   wb_valid/wb_phys/wb_data           write-back into the register file
//   ret_valid/ret_phys                 retire frees a physical register
//   br_resolve/br_restore/br_ckpt_id   release oldest / roll back to a checkpoint
//   free_count, ckpt_full              free registers, all checkpoints live
module rename_unit
  import rename_pkg::*;
#(
  parameter int ARCH_REGS  = ARCH_REGS_DEF,
  parameter int PHYS_REGS  = PHYS_REGS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_CKPT   = NUM_CKPT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ren_valid,
  input  logic                          ren_is_branch,
  input  logic [idx_width(ARCH_REGS)-1:0] ren_rs,
  input  logic [idx_width(ARCH_REGS)-1:0] ren_rt,
  input  logic [idx_width(ARCH_REGS)-1:0] ren_rw,
  input  logic                          ren_uses_rs,
  input  logic                          ren_uses_rt,
  input  logic                          ren_uses_rw,
  output logic                          ren_ready,
  output logic [idx_width(PHYS_REGS)-1:0] rs_phys,
  output logic [idx_width(PHYS_REGS)-1:0] rt_phys,
  output logic [DATA_WIDTH-1:0]         rs_data,
  output logic [DATA_WIDTH-1:0]         rt_data,
  output logic                          rs_rdy,
  output logic                          rt_rdy,
  output logic [idx_width(PHYS_REGS)-1:0] rw_phys_new,
  output logic [idx_width(PHYS_REGS)-1:0] rw_phys_old,
  output logic [idx_width(NUM_CKPT)-1:0]  ckpt_id,
  input  logic                          wb_valid,
  input  logic [idx_width(PHYS_REGS)-1:0] wb_phys,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  input  logic                          ret_valid,
  input  logic [idx_width(PHYS_REGS)-1:0] ret_phys,
  input  logic                          br_resolve,
  input  logic                          br_restore,
  input  logic [idx_width(NUM_CKPT)-1:0]  br_ckpt_id,
  output logic [idx_width(PHYS_REGS):0]   free_count,
  output logic                          ckpt_full
);

  localparam int PW = idx_width(PHYS_REGS);
  localparam int CW = idx_width(NUM_CKPT);

  logic [PW-1:0]         map [ARCH_REGS];
  logic [PHYS_REGS-1:0]  free_vec;
  logic [PHYS_REGS-1:0]  ready_vec;
  logic [DATA_WIDTH-1:0] regs [PHYS_REGS];
  logic [PW-1:0]         ck_map [NUM_CKPT][ARCH_REGS];
  logic [PHYS_REGS-1:0]  ck_free [NUM_CKPT];
  logic [CW-1:0]         head;
  logic [CW-1:0]         tail;
  logic [CW:0]           count;

  logic [PW-1:0]         alloc_idx;
  logic                  alloc_ok;
  logic [PW:0]           pop;

  free_list_alloc #(.N(PHYS_REGS), .IW(PW)) u_alloc (
    .vec   (free_vec),
    .idx   (alloc_idx),
    .valid (alloc_ok),
    .count (pop)
  );

  logic                 dest_live, fire, do_alloc, do_ckpt, do_ret, do_wb, do_resolve;
  logic                 rs_byp, rt_byp;
  logic [PHYS_REGS-1:0] ret_mask, free_next, ready_next;
  logic [CW-1:0]        rst_tail, rst_span;

  assign free_count = pop;
  assign ckpt_full  = (count == (CW + 1)'(NUM_CKPT));
  assign dest_live  = ren_uses_rw && (ren_rw != '0);
  // A restore owns this cycle; decode must re-present after the rollback.
  assign ren_ready  = !br_restore && (!dest_live || alloc_ok) && (!ren_is_branch || !ckpt_full);
  assign fire       = ren_valid && ren_ready;
  assign do_alloc   = fire && dest_live;
  assign do_ckpt    = fire && ren_is_branch;
  assign do_ret     = ret_valid && (ret_phys != '0);
  assign do_wb      = wb_valid && (wb_phys != '0);
  assign do_resolve = br_resolve && (count != '0);

  assign rw_phys_old = dest_live ? map[ren_rw] : '0;
  assign rw_phys_new = dest_live ? alloc_idx : '0;
  assign ckpt_id     = tail;

  // Sources see the map as it stands before this instruction's own dest update.
  always_comb begin
    rs_phys = ren_uses_rs ? map[ren_rs] : '0;
    rt_phys = ren_uses_rt ? map[ren_rt] : '0;
    rs_byp  = do_wb && (wb_phys == rs_phys);
    rt_byp  = do_wb && (wb_phys == rt_phys);
    rs_data = !ren_uses_rs ? '0 : (rs_byp ? wb_data : regs[rs_phys]);
    rt_data = !ren_uses_rt ? '0 : (rt_byp ? wb_data : regs[rt_phys]);
    rs_rdy  = !ren_uses_rs || rs_byp || ready_vec[rs_phys];
    rt_rdy  = !ren_uses_rt || rt_byp || ready_vec[rt_phys];
  end

  always_comb begin
    ret_mask   = '0;
    free_next  = free_vec;
    ready_next = ready_vec;
    if (do_ret) ret_mask[ret_phys] = 1'b1;
    if (do_alloc) begin
      free_next[alloc_idx]  = 1'b0;
      ready_next[alloc_idx] = 1'b0;
    end
    free_next = free_next | ret_mask;
    if (do_wb) ready_next[wb_phys] = 1'b1;
    rst_tail = br_ckpt_id + CW'(1);
    rst_span = rst_tail - head;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map[i] <= PW'(i);
      for (int i = 0; i < PHYS_REGS; i++) begin
        free_vec[i] <= (i >= ARCH_REGS);
        regs[i]     <= '0;
      end
      ready_vec <= '1;
      for (int k = 0; k < NUM_CKPT; k++) begin
        ck_free[k] <= '0;
        for (int i = 0; i < ARCH_REGS; i++) ck_map[k][i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      ready_vec <= ready_next;
      if (do_wb) regs[wb_phys] <= wb_data;
      // Dead slots also collect retire bits; they are fully rewritten when next taken.
      for (int k = 0; k < NUM_CKPT; k++) ck_free[k] <= ck_free[k] | ret_mask;

      if (br_restore) begin
        for (int i = 0; i < ARCH_REGS; i++) map[i] <= ck_map[br_ckpt_id][i];
        free_vec <= ck_free[br_ckpt_id] | ret_mask;
        tail     <= rst_tail;
        // The target slot itself stays live, so a zero span means every slot is live.
        count    <= (rst_span == '0) ? (CW + 1)'(NUM_CKPT) : {1'b0, rst_span};
      end else begin
        if (do_alloc) map[ren_rw] <= alloc_idx;
        free_vec <= free_next;
        head     <= head + CW'(do_resolve);
        count    <= count + (CW + 1)'(do_ckpt) - (CW + 1)'(do_resolve);
        if (do_ckpt) begin
          tail          <= tail + CW'(1);
          ck_free[tail] <= free_next;
          for (int i = 0; i < ARCH_REGS; i++) ck_map[tail][i] <= map[i];
          if (do_alloc) ck_map[tail][ren_rw] <= alloc_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// tb/tb_rename_unit.sv - self-checking bench for rename_unit
module tb_rename_unit;
  import rename_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      ren_valid, ren_is_branch, ren_uses_rs, ren_uses_rt, ren_uses_rw, ren_ready;
  arch_idx_t ren_rs, ren_rt, ren_rw;
  phys_idx_t rs_phys, rt_phys, rw_phys_new, rw_phys_old, wb_phys, ret_phys;
  logic [31:0] rs_data, rt_data, wb_data;
  logic      rs_rdy, rt_rdy, wb_valid, ret_valid, br_resolve, br_restore, ckpt_full;
  ckpt_idx_t ckpt_id, br_ckpt_id;
  logic [PHYS_W:0] free_count;

  rename_unit dut (
    .clk(clk), .reset(reset),
    .ren_valid(ren_valid), .ren_is_branch(ren_is_branch),
    .ren_rs(ren_rs), .ren_rt(ren_rt), .ren_rw(ren_rw),
    .ren_uses_rs(ren_uses_rs), .ren_uses_rt(ren_uses_rt), .ren_uses_rw(ren_uses_rw),
    .ren_ready(ren_ready),
    .rs_phys(rs_phys), .rt_phys(rt_phys), .rs_data(rs_data), .rt_data(rt_data),
    .rs_rdy(rs_rdy), .rt_rdy(rt_rdy),
    .rw_phys_new(rw_phys_new), .rw_phys_old(rw_phys_old), .ckpt_id(ckpt_id),
    .wb_valid(wb_valid), .wb_phys(wb_phys), .wb_data(wb_data),
    .ret_valid(ret_valid), .ret_phys(ret_phys),
    .br_resolve(br_resolve), .br_restore(br_restore), .br_ckpt_id(br_ckpt_id),
    .free_count(free_count), .ckpt_full(ckpt_full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit valid, br, urs, urt, urw, ret, resolve, restore, wb;
    int rs, rt, rw, ret_phys, ckid, wb_phys;
    int unsigned wb_data;
    int e_ready, e_new, e_old, e_fc, e_rsp, e_full, e_ckid;
    longint e_rsd;
  } vec_t;

  // Reference model: map table, free/ready sets, register values and a queue of live snapshots.
  typedef struct packed {
    ckpt_idx_t id;
    ckpt_t     snap;
  } mck_t;

  phys_idx_t [ARCH_REGS_DEF-1:0] m_map;
  logic [PHYS_REGS_DEF-1:0]      m_free, m_rdy;
  logic [31:0]                   m_regs [PHYS_REGS_DEF];
  mck_t                          ck_q[$];
  int                            m_tail;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t rn(input int rw, input int rs, input bit br,
                              input int e_ready, input int e_new, input int e_old, input int e_fc);
    vec_t v;
    v = '{default: 0};
    v.valid = (rw >= 0) || (rs >= 0) || br;
    v.br = br;
    v.urw = (rw >= 0);  v.rw = (rw >= 0) ? rw : 0;
    v.urs = (rs >= 0);  v.rs = (rs >= 0) ? rs : 0;
    v.e_ready = e_ready; v.e_new = e_new; v.e_old = e_old; v.e_fc = e_fc;
    v.e_rsp = -1; v.e_full = -1; v.e_ckid = -1; v.e_rsd = -1;
    return v;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < PHYS_REGS_DEF; i++) if (m_free[i]) return i;
    return 0;
  endfunction

  task automatic model_init();
    for (int i = 0; i < ARCH_REGS_DEF; i++) m_map[i] = phys_idx_t'(i);
    for (int i = 0; i < PHYS_REGS_DEF; i++) begin
      m_free[i] = (i >= ARCH_REGS_DEF);
      m_regs[i] = '0;
    end
    m_rdy  = '1;
    m_tail = 0;
    ck_q.delete();
  endtask

  // Reset with busy inputs: everything presented during reset must be dropped.
  task automatic do_reset();
    reset = 1'b1;
    ren_valid = 1'b1; ren_is_branch = 1'b1; ren_uses_rw = 1'b1; ren_rw = 3;
    ren_uses_rs = 1'b0; ren_uses_rt = 1'b0; ren_rs = 0; ren_rt = 0;
    wb_valid = 1'b1; wb_phys = 1; wb_data = 32'hffff_ffff;
    ret_valid = 1'b1; ret_phys = 3; br_resolve = 1'b1; br_restore = 1'b0; br_ckpt_id = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  task automatic run(input vec_t v);
    int fc, nw, rsp, rtp;
    bit dest, rdy, fire, do_res;
    mck_t t;
    ren_valid = v.valid; ren_is_branch = v.br;
    ren_rs = arch_idx_t'(v.rs); ren_rt = arch_idx_t'(v.rt); ren_rw = arch_idx_t'(v.rw);
    ren_uses_rs = v.urs; ren_uses_rt = v.urt; ren_uses_rw = v.urw;
    wb_valid = v.wb; wb_phys = phys_idx_t'(v.wb_phys); wb_data = v.wb_data;
    ret_valid = v.ret; ret_phys = phys_idx_t'(v.ret_phys);
    br_resolve = v.resolve; br_restore = v.restore; br_ckpt_id = ckpt_idx_t'(v.ckid);
    #4;
    fc   = $countones(m_free);
    nw   = m_lowest();
    dest = v.urw && (v.rw != 0);
    rdy  = !v.restore && (!dest || fc > 0) && (!v.br || ck_q.size() < NUM_CKPT_DEF);
    rsp  = v.urs ? int'(m_map[v.rs]) : 0;
    rtp  = v.urt ? int'(m_map[v.rt]) : 0;
    chk("ren_ready", ren_ready, rdy);
    chk("free_count", free_count, fc);
    chk("ckpt_full", ckpt_full, ck_q.size() == NUM_CKPT_DEF);
    chk("ckpt_id", ckpt_id, m_tail);
    chk("rw_phys_old", rw_phys_old, dest ? int'(m_map[v.rw]) : 0);
    if (!dest || rdy) chk("rw_phys_new", rw_phys_new, dest ? nw : 0);
    chk("rs_phys", rs_phys, rsp);
    chk("rt_phys", rt_phys, rtp);
    chk("rs_data", rs_data, !v.urs ? 0 :
        ((v.wb && v.wb_phys != 0 && v.wb_phys == rsp) ? longint'(v.wb_data) : longint'(m_regs[rsp])));
    chk("rt_data", rt_data, !v.urt ? 0 :
        ((v.wb && v.wb_phys != 0 && v.wb_phys == rtp) ? longint'(v.wb_data) : longint'(m_regs[rtp])));
    if (v.urs) chk("rs_rdy", rs_rdy, (v.wb && v.wb_phys != 0 && v.wb_phys == rsp) || m_rdy[rsp]);
    if (v.urt) chk("rt_rdy", rt_rdy, (v.wb && v.wb_phys != 0 && v.wb_phys == rtp) || m_rdy[rtp]);
    if (v.e_ready >= 0) chk("tbl_ready", ren_ready, v.e_ready);
    if (v.e_new >= 0)   chk("tbl_new", rw_phys_new, v.e_new);
    if (v.e_old >= 0)   chk("tbl_old", rw_phys_old, v.e_old);
    if (v.e_fc >= 0)    chk("tbl_free_count", free_count, v.e_fc);
    if (v.e_rsp >= 0)   chk("tbl_rs_phys", rs_phys, v.e_rsp);
    if (v.e_rsd >= 0)   chk("tbl_rs_data", rs_data, v.e_rsd);
    if (v.e_full >= 0)  chk("tbl_ckpt_full", ckpt_full, v.e_full);
    if (v.e_ckid >= 0)  chk("tbl_ckpt_id", ckpt_id, v.e_ckid);
    @(posedge clk);
    fire   = v.valid && rdy;
    do_res = v.resolve && ck_q.size() > 0;
    if (v.ret && v.ret_phys != 0) begin
      foreach (ck_q[k]) begin
        t = ck_q[k];
        t.snap.free[v.ret_phys] = 1'b1;
        ck_q[k] = t;
      end
    end
    if (v.restore) begin
      while (ck_q.size() > 0 && int'(ck_q[$].id) != v.ckid) void'(ck_q.pop_back());
      if (ck_q.size() > 0) begin
        m_map  = ck_q[$].snap.map;
        m_free = ck_q[$].snap.free;
      end
      m_tail = (v.ckid + 1) % NUM_CKPT_DEF;
    end else begin
      if (fire && dest) begin
        m_map[v.rw] = phys_idx_t'(nw);
        m_free[nw]  = 1'b0;
        m_rdy[nw]   = 1'b0;
      end
      if (v.ret && v.ret_phys != 0) m_free[v.ret_phys] = 1'b1;
      if (do_res) void'(ck_q.pop_front());
      if (fire && v.br) begin
        t.id = ckpt_idx_t'(m_tail);
        t.snap.map = m_map;
        t.snap.free = m_free;
        ck_q.push_back(t);
        m_tail = (m_tail + 1) % NUM_CKPT_DEF;
      end
    end
    if (v.wb && v.wb_phys != 0) begin
      m_regs[v.wb_phys] = v.wb_data;
      m_rdy[v.wb_phys]  = 1'b1;
    end
    #1;
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;

    tbl[0] = rn(-1, -1, 0, 1, 0, 0, 32);  tbl[0].e_full = 0;
    tbl[1] = rn(5, -1, 0, 1, 32, 5, 32);
    tbl[2] = rn(5, -1, 0, 1, 33, 32, 31);
    tbl[3] = rn(5, -1, 0, 1, 34, 33, 30);
    tbl[4] = rn(5, 5, 0, 1, 35, 34, 29);
    tbl[4].e_rsp = 34; tbl[4].wb = 1; tbl[4].wb_phys = 34; tbl[4].wb_data = 32'hABCD;
    tbl[4].e_rsd = 32'hABCD;
    tbl[5] = rn(-1, 3, 0, 1, 0, 0, 28);   tbl[5].e_rsp = 3; tbl[5].e_rsd = 0;
    tbl[6] = rn(0, -1, 0, 1, 0, 0, 28);
    tbl[7] = rn(-1, 5, 0, 1, 0, 0, 28);   tbl[7].e_rsp = 35;

    do_reset();
    for (int i = 0; i < 8; i++) run(tbl[i]);

    // Exhaust the free list, then retire phys 5 and reuse it the next cycle.
    do_reset();
    for (int i = 0; i < 32; i++) run(rn(1 + i % 31, -1, 0, 1, 32 + i, -1, 32 - i));
    v = rn(9, -1, 0, 0, -1, -1, 0); v.ret = 1; v.ret_phys = 5; run(v);
    run(rn(9, -1, 0, 1, 5, -1, 1));

    // Checkpoint, rename, roll back; then fill and drain the checkpoint stack.
    do_reset();
    v = rn(-1, -1, 1, 1, 0, 0, 32); v.e_ckid = 0; run(v);
    run(rn(7, -1, 0, 1, 32, 7, 32));
    v = rn(9, -1, 0, 0, -1, -1, 31); v.restore = 1; v.ckid = 0; run(v);
    v = rn(8, 7, 0, 1, 32, 8, 32); v.e_rsp = 7; run(v);
    for (int i = 1; i < 4; i++) begin
      v = rn(-1, -1, 1, 1, 0, 0, 31); v.e_ckid = i; v.e_full = 0; run(v);
    end
    v = rn(-1, -1, 1, 0, -1, -1, 31); v.e_full = 1; run(v);
    v = rn(-1, -1, 0, 1, 0, 0, 31); v.resolve = 1; v.e_full = 1; run(v);
    v = rn(-1, -1, 1, 1, 0, 0, 31); v.e_full = 0; v.e_ckid = 0; run(v);

    // A register retired while a checkpoint is live stays free after restoring it.
    do_reset();
    run(rn(1, -1, 0, 1, 32, 1, 32));
    run(rn(2, -1, 0, 1, 33, 2, 31));
    v = rn(-1, -1, 1, 1, 0, 0, 30); v.e_ckid = 0; run(v);
    v = rn(-1, -1, 0, 1, 0, 0, 30); v.ret = 1; v.ret_phys = 33; run(v);
    v = rn(-1, -1, 0, 0, -1, -1, 31); v.restore = 1; v.ckid = 0; run(v);
    run(rn(3, -1, 0, 1, 33, 3, 31));

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) < 3) do_reset();
      v = rn(-1, -1, 0, -1, -1, -1, -1);
      v.valid = ($urandom_range(0, 9) < 7);
      v.br    = ($urandom_range(0, 4) == 0);
      v.rs = $urandom_range(0, 31); v.rt = $urandom_range(0, 31); v.rw = $urandom_range(0, 31);
      v.urs = 1'($urandom_range(0, 1)); v.urt = 1'($urandom_range(0, 1));
      v.urw = ($urandom_range(0, 3) != 0);
      v.ret = ($urandom_range(0, 9) < 3); v.ret_phys = $urandom_range(0, 63);
      v.wb  = ($urandom_range(0, 9) < 4); v.wb_phys = $urandom_range(0, 63);
      v.wb_data = $urandom;
      if (ck_q.size() > 0) begin
        v.resolve = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) begin
          v.restore = 1;
          v.ckid = int'(ck_q[$urandom_range(0, ck_q.size() - 1)].id);
        end
      end
      run(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
